// File: rtl/jfpjc_pkg.sv
// Shared types and constants for the camera ROI windowing path.
// Holds the window-config struct, counter-width helper and default geometry.
package jfpjc_pkg;

    // Field width of a latched window coordinate; bounds use one extra bit.
    localparam int WIN_FW = 16;

    // Default sensor and window geometry.
    localparam int SENSOR_COLS = 324;
    localparam int SENSOR_ROWS = 244;
    localparam int WIN_LEFT    = 2;
    localparam int WIN_TOP     = 2;
    localparam int WIN_COLS    = 320;
    localparam int WIN_ROWS    = 240;

    // Bit positions of the synchronised camera timing signals.
    localparam int SIG_PCLK = 0;
    localparam int SIG_HS   = 1;
    localparam int SIG_VS   = 2;
    localparam int NUM_SIGS = 3;

    typedef logic [WIN_FW-1:0] win_field_t;
    typedef logic [WIN_FW:0]   bound_t;

    typedef struct packed {
        win_field_t left;
        win_field_t top;
        win_field_t width;
        win_field_t height;
    } roi_win_t;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_ARMED,
        FS_EMIT
    } frame_state_t;

    // Counter width able to hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/pixel_roi_window_sync_edge_detect.sv
// Multi-bit synchroniser with rising/falling edge detection.
// Ports: clock, nreset, async_in[WIDTH] -> level, rise, fall (one-cycle).
// Edges are held off until the pipeline has refilled after reset, so a
// signal already high at reset release never produces a false rise.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 3
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   prev_q;
    logic [SYNC_STAGES:0] fill_q;
    logic               primed;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign primed = fill_q[SYNC_STAGES];
    assign level  = sync_q[SYNC_STAGES-1];
    assign rise   = {WIDTH{primed}} & level & ~prev_q;
    assign fall   = {WIDTH{primed}} & ~level & prev_q;

endmodule

// File: rtl/pixel_roi_window.sv
// Crops a region of interest out of an asynchronous camera pixel stream.
// Inputs: clock, nreset, raw pixclk/hsync/vsync/pixdata, cfg_* window.
// Outputs: pix_valid/pix_data strobe, line_start, frame_start, frame_end,
// line_short_err pulses. Define ROI_DECIMATE_EN to add cfg_decimate.
module pixel_roi_window
    import jfpjc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int MAX_COLS    = 1024,
    parameter int MAX_ROWS    = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clock,
    input  logic                         nreset,
    input  logic                         pixclk_in,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic [DATA_W-1:0]            pixdata_in,
    input  logic [cnt_w(MAX_COLS)-1:0]   cfg_left,
    input  logic [cnt_w(MAX_COLS)-1:0]   cfg_width,
    input  logic [cnt_w(MAX_ROWS)-1:0]   cfg_top,
    input  logic [cnt_w(MAX_ROWS)-1:0]   cfg_height,
`ifdef ROI_DECIMATE_EN
    input  logic                         cfg_decimate,
`endif
    output logic                         pix_valid,
    output logic [DATA_W-1:0]            pix_data,
    output logic                         line_start,
    output logic                         frame_start,
    output logic                         frame_end,
    output logic                         line_short_err
);

    localparam int CW = cnt_w(MAX_COLS);
    localparam int RW = cnt_w(MAX_ROWS);

    logic [NUM_SIGS-1:0] sig_lvl;
    logic [NUM_SIGS-1:0] sig_rise;
    logic [NUM_SIGS-1:0] sig_fall;
    logic                unused_edges;

    logic [DATA_W-1:0]   data_q [SYNC_STAGES];
    logic [CW-1:0]       col_q;
    logic [RW-1:0]       row_q;
    roi_win_t            win_q;
    frame_state_t        state_q;
    frame_state_t        state_d;
    logic                line_started_q;
`ifdef ROI_DECIMATE_EN
    logic                dec_q;
`endif

    logic   pclk_rise;
    logic   hs_lvl;
    logic   hs_fall;
    logic   vs_lvl;
    logic   vs_rise;
    logic   vs_fall;
    bound_t col_x;
    bound_t row_x;
    bound_t col_end;
    bound_t row_end;
    logic   in_frame;
    logic   in_col;
    logic   in_row;
    logic   dec_ok;
    logic   hit;
    logic   line_end;
    logic   short_err;
    logic   frame_done;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (NUM_SIGS)
    ) u_sync (
        .clock    (clock),
        .nreset   (nreset),
        .async_in ({vsync_in, hsync_in, pixclk_in}),
        .level    (sig_lvl),
        .rise     (sig_rise),
        .fall     (sig_fall)
    );

    assign pclk_rise = sig_rise[SIG_PCLK];
    assign hs_lvl    = sig_lvl[SIG_HS];
    assign hs_fall   = sig_fall[SIG_HS];
    assign vs_lvl    = sig_lvl[SIG_VS];
    assign vs_rise   = sig_rise[SIG_VS];
    assign vs_fall   = sig_fall[SIG_VS];

    assign unused_edges = &{1'b0, sig_lvl[SIG_PCLK],
                            sig_rise[SIG_HS], sig_fall[SIG_PCLK]};

    // Pixel data delayed to stay aligned with the synchronised pixclk.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q[0] <= pixdata_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    always_comb begin
        col_x   = bound_t'(col_q);
        row_x   = bound_t'(row_q);
        col_end = {1'b0, win_q.left} + {1'b0, win_q.width};
        row_end = {1'b0, win_q.top} + {1'b0, win_q.height};
        in_frame = (state_q != FS_IDLE);
        in_col  = (col_x >= {1'b0, win_q.left}) && (col_x < col_end);
        in_row  = (row_x >= {1'b0, win_q.top}) && (row_x < row_end);
        dec_ok  = 1'b1;
`ifdef ROI_DECIMATE_EN
        // Even offsets from the origin: parity of col matches parity of left.
        if (dec_q) begin
            dec_ok = ~(col_q[0] ^ win_q.left[0]) & ~(row_q[0] ^ win_q.top[0]);
        end
`endif
        hit = in_frame & pclk_rise & hs_lvl & vs_lvl & in_col & in_row & dec_ok;
        // vsync dropping mid-line also closes the line.
        line_end   = in_frame & (hs_fall | (vs_fall & hs_lvl));
        short_err  = line_end & in_row & (col_x < col_end);
        frame_done = 1'b0;
        state_d    = state_q;
        unique case (state_q)
            FS_IDLE: begin
                if (vs_rise) state_d = FS_ARMED;
            end
            FS_ARMED: begin
                if (vs_fall)  state_d = FS_IDLE;
                else if (hit) state_d = FS_EMIT;
            end
            FS_EMIT: begin
                if (vs_fall) begin
                    state_d    = FS_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q        <= FS_IDLE;
            win_q          <= '0;
`ifdef ROI_DECIMATE_EN
            dec_q          <= 1'b0;
`endif
            col_q          <= '0;
            row_q          <= '0;
            line_started_q <= 1'b0;
            pix_valid      <= 1'b0;
            pix_data       <= '0;
            line_start     <= 1'b0;
            frame_start    <= 1'b0;
            frame_end      <= 1'b0;
            line_short_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (vs_rise) begin
                win_q.left   <= win_field_t'(cfg_left);
                win_q.top    <= win_field_t'(cfg_top);
                win_q.width  <= win_field_t'(cfg_width);
                win_q.height <= win_field_t'(cfg_height);
`ifdef ROI_DECIMATE_EN
                dec_q        <= cfg_decimate;
`endif
            end
            if (!hs_lvl) begin
                col_q <= '0;
            end else if (pclk_rise && col_q != CW'(MAX_COLS)) begin
                col_q <= col_q + CW'(1);
            end
            if (!vs_lvl) begin
                row_q <= '0;
            end else if (hs_fall && row_q != RW'(MAX_ROWS)) begin
                row_q <= row_q + RW'(1);
            end
            if (!hs_lvl || !in_frame) begin
                line_started_q <= 1'b0;
            end else if (hit) begin
                line_started_q <= 1'b1;
            end
            pix_valid <= hit;
            if (hit) begin
                pix_data <= data_q[SYNC_STAGES-1];
            end
            line_start     <= hit & ~line_started_q;
            frame_start    <= hit & (state_q == FS_ARMED);
            frame_end      <= frame_done;
            line_short_err <= short_err;
        end
    end

endmodule

// File: tb/tb_pixel_roi_window.sv
// Directed self-checking bench for pixel_roi_window.
// Pixel data encodes {row, col} so each strobe identifies its position.
module tb_pixel_roi_window;

    localparam int SC = 36;
    localparam int SR = 28;
    localparam int WL = 2;
    localparam int WT = 2;
    localparam int WW = 32;
    localparam int WH = 24;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        pixclk_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [15:0] pixdata_in = '0;
    logic [10:0] cfg_left = '0;
    logic [10:0] cfg_width = '0;
    logic [10:0] cfg_top = '0;
    logic [10:0] cfg_height = '0;
`ifdef ROI_DECIMATE_EN
    logic        cfg_decimate = 1'b0;
`endif
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        line_start;
    logic        frame_start;
    logic        frame_end;
    logic        line_short_err;

    int n_checks = 0;
    int n_fail = 0;

    int exp_left = 0;
    int exp_top = 0;
    int exp_w = 0;
    int exp_h = 0;
    int exp_dec = 0;

    int short_row = -1;
    int short_len = 0;
    int rst_row = -1;
    int chg_row = -1;
    int chg_left = 0;
    logic rst_seen = 1'b0;
    int pv_at_rel = 0;

    int pv_n = 0;
    int ls_n = 0;
    int fs_n = 0;
    int fe_n = 0;
    int se_n = 0;
    int same_n = 0;
    int oob_n = 0;
    int row_cnt [256];
    logic [15:0] first_data = '0;
    int mr;
    int mc;

    int s_pv, s_ls, s_fs, s_fe, s_se, s_same, s_oob;
    int s_row [256];

    pixel_roi_window #(
        .DATA_W      (16),
        .MAX_COLS    (1024),
        .MAX_ROWS    (1024),
        .SYNC_STAGES (2)
    ) dut (
        .clock          (clock),
        .nreset         (nreset),
        .pixclk_in      (pixclk_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .pixdata_in     (pixdata_in),
        .cfg_left       (cfg_left),
        .cfg_width      (cfg_width),
        .cfg_top        (cfg_top),
        .cfg_height     (cfg_height),
`ifdef ROI_DECIMATE_EN
        .cfg_decimate   (cfg_decimate),
`endif
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .line_start     (line_start),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .line_short_err (line_short_err)
    );

    always #5 clock = ~clock;

    function automatic bit in_exp(input int r, input int c);
        bit ok;
        ok = (c >= exp_left) && (c < exp_left + exp_w) &&
             (r >= exp_top) && (r < exp_top + exp_h);
        if (exp_dec != 0) begin
            ok = ok && (((c - exp_left) % 2) == 0) &&
                 (((r - exp_top) % 2) == 0);
        end
        return ok;
    endfunction

    always @(negedge clock) begin
        if (pix_valid === 1'b1) begin
            pv_n++;
            mr = int'(pix_data[15:8]);
            mc = int'(pix_data[7:0]);
            row_cnt[mr]++;
            if (!in_exp(mr, mc)) oob_n++;
        end
        if ((line_start === 1'b1 || frame_start === 1'b1) &&
            pix_valid !== 1'b1) oob_n++;
        if (line_start === 1'b1) ls_n++;
        if (frame_start === 1'b1) begin
            fs_n++;
            first_data = pix_data;
        end
        if (frame_end === 1'b1) fe_n++;
        if (line_short_err === 1'b1) se_n++;
        if (line_short_err === 1'b1 && frame_end === 1'b1) same_n++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic snap();
        s_pv = pv_n;
        s_ls = ls_n;
        s_fs = fs_n;
        s_fe = fe_n;
        s_se = se_n;
        s_same = same_n;
        s_oob = oob_n;
        for (int i = 0; i < 256; i++) s_row[i] = row_cnt[i];
    endtask

    task automatic set_win(input int l, input int t,
                           input int w, input int h);
        cfg_left = 11'(l);
        cfg_top = 11'(t);
        cfg_width = 11'(w);
        cfg_height = 11'(h);
        exp_left = l;
        exp_top = t;
        exp_w = w;
        exp_h = h;
        exp_dec = 0;
`ifdef ROI_DECIMATE_EN
        cfg_decimate = 1'b0;
`endif
        short_row = -1;
        rst_row = -1;
        chg_row = -1;
    endtask

    task automatic drive_frame();
        int n;
        vsync_in = 1'b1;
        cyc(4);
        for (int r = 0; r < SR; r++) begin
            if (r == rst_row) begin
                nreset = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    #1;
                    rst_seen = rst_seen | pix_valid | line_start |
                               frame_start | frame_end |
                               line_short_err | (|pix_data);
                    @(negedge clock);
                end
                nreset = 1'b1;
                pv_at_rel = pv_n;
            end
            if (r == chg_row) cfg_left = 11'(chg_left);
            hsync_in = 1'b1;
            cyc(2);
            n = (r == short_row) ? short_len : SC;
            for (int c = 0; c < n; c++) begin
                pixdata_in = {8'(r), 8'(c)};
                pixclk_in = 1'b0;
                cyc(2);
                pixclk_in = 1'b1;
                cyc(2);
            end
            pixclk_in = 1'b0;
            cyc(2);
            hsync_in = 1'b0;
            cyc(4);
        end
        vsync_in = 1'b0;
        cyc(10);
    endtask

    task automatic test_reset();
        cyc(3);
        #1;
        n_checks++;
        if (pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pix_valid: got %b want 0", pix_valid);
        end
        n_checks++;
        if (pix_data !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_pix_data: got %h want 0", pix_data);
        end
        n_checks++;
        if (line_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_line_start: got %b want 0", line_start);
        end
        n_checks++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_frame_start: got %b want 0", frame_start);
        end
        n_checks++;
        if (frame_end !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_frame_end: got %b want 0", frame_end);
        end
        n_checks++;
        if (line_short_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_short_err: got %b want 0", line_short_err);
        end
        @(negedge clock);
        nreset = 1'b1;
        cyc(6);
    endtask

    task automatic test_latency();
        set_win(0, 0, 4, 4);
        snap();
        vsync_in = 1'b1;
        cyc(6);
        hsync_in = 1'b1;
        cyc(6);
        pixdata_in = 16'h0203;
        pixclk_in = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_early: got %b want 0", pix_valid);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (pix_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_valid: got %b want 1", pix_valid);
        end
        n_checks++;
        if (pix_data !== 16'h0203) begin
            n_fail++;
            $display("FAIL lat_data: got %h want 0203", pix_data);
        end
        n_checks++;
        if (line_start !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_line_start: got %b want 1", line_start);
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_frame_start: got %b want 1", frame_start);
        end
        @(negedge clock);
        pixclk_in = 1'b0;
        cyc(4);
        vsync_in = 1'b0;
        cyc(8);
        hsync_in = 1'b0;
        cyc(8);
        n_checks++;
        if (pv_n - s_pv !== 1) begin
            n_fail++;
            $display("FAIL lat_pv_count: got %0d want 1", pv_n - s_pv);
        end
        n_checks++;
        if (se_n - s_se !== 1) begin
            n_fail++;
            $display("FAIL vs_mid_short: got %0d want 1", se_n - s_se);
        end
        n_checks++;
        if (fe_n - s_fe !== 1) begin
            n_fail++;
            $display("FAIL vs_mid_fe: got %0d want 1", fe_n - s_fe);
        end
        n_checks++;
        if (same_n - s_same !== 1) begin
            n_fail++;
            $display("FAIL vs_mid_same: got %0d want 1", same_n - s_same);
        end
    endtask

    task automatic test_full_frame();
        set_win(WL, WT, WW, WH);
        snap();
        drive_frame();
        n_checks++;
        if (pv_n - s_pv !== WW * WH) begin
            n_fail++;
            $display("FAIL full_pv: got %0d want %0d", pv_n - s_pv, WW * WH);
        end
        n_checks++;
        if (ls_n - s_ls !== WH) begin
            n_fail++;
            $display("FAIL full_ls: got %0d want %0d", ls_n - s_ls, WH);
        end
        n_checks++;
        if (fs_n - s_fs !== 1) begin
            n_fail++;
            $display("FAIL full_fs: got %0d want 1", fs_n - s_fs);
        end
        n_checks++;
        if (fe_n - s_fe !== 1) begin
            n_fail++;
            $display("FAIL full_fe: got %0d want 1", fe_n - s_fe);
        end
        n_checks++;
        if (se_n - s_se !== 0) begin
            n_fail++;
            $display("FAIL full_se: got %0d want 0", se_n - s_se);
        end
        n_checks++;
        if (oob_n - s_oob !== 0) begin
            n_fail++;
            $display("FAIL full_window: got %0d stray want 0", oob_n - s_oob);
        end
        n_checks++;
        if (first_data !== 16'h0202) begin
            n_fail++;
            $display("FAIL full_first: got %h want 0202", first_data);
        end
    endtask

    task automatic test_zero_width();
        set_win(WL, WT, 0, WH);
        snap();
        drive_frame();
        n_checks++;
        if (pv_n - s_pv !== 0) begin
            n_fail++;
            $display("FAIL zw_pv: got %0d want 0", pv_n - s_pv);
        end
        n_checks++;
        if (fs_n - s_fs !== 0) begin
            n_fail++;
            $display("FAIL zw_fs: got %0d want 0", fs_n - s_fs);
        end
        n_checks++;
        if (fe_n - s_fe !== 0) begin
            n_fail++;
            $display("FAIL zw_fe: got %0d want 0", fe_n - s_fe);
        end
    endtask

    task automatic test_cfg_midframe();
        set_win(WL, WT, WW, WH);
        chg_row = 5;
        chg_left = 10;
        snap();
        drive_frame();
        n_checks++;
        if (pv_n - s_pv !== WW * WH) begin
            n_fail++;
            $display("FAIL mid_pv_cur: got %0d want %0d", pv_n - s_pv, WW * WH);
        end
        n_checks++;
        if (oob_n - s_oob !== 0) begin
            n_fail++;
            $display("FAIL mid_window_cur: got %0d stray want 0", oob_n - s_oob);
        end
        chg_row = -1;
        exp_left = 10;
        snap();
        drive_frame();
        n_checks++;
        if (first_data !== 16'h020A) begin
            n_fail++;
            $display("FAIL mid_first_next: got %h want 020a", first_data);
        end
        n_checks++;
        if (pv_n - s_pv !== (SC - 10) * WH) begin
            n_fail++;
            $display("FAIL mid_pv_next: got %0d want %0d",
                     pv_n - s_pv, (SC - 10) * WH);
        end
        n_checks++;
        if (oob_n - s_oob !== 0) begin
            n_fail++;
            $display("FAIL mid_window_next: got %0d stray want 0", oob_n - s_oob);
        end
    endtask

    task automatic test_short_line();
        int bad;
        int want;
        set_win(WL, WT, WW, WH);
        short_row = 5;
        short_len = 10;
        snap();
        drive_frame();
        bad = 0;
        for (int r = WT; r < WT + WH; r++) begin
            want = (r == 5) ? (short_len - WL) : WW;
            if (row_cnt[r] - s_row[r] != want) bad++;
        end
        n_checks++;
        if (se_n - s_se !== 1) begin
            n_fail++;
            $display("FAIL short_err_count: got %0d want 1", se_n - s_se);
        end
        n_checks++;
        if (row_cnt[5] - s_row[5] !== short_len - WL) begin
            n_fail++;
            $display("FAIL short_row5: got %0d want %0d",
                     row_cnt[5] - s_row[5], short_len - WL);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL short_rows: got %0d bad rows want 0", bad);
        end
        n_checks++;
        if (pv_n - s_pv !== WW * (WH - 1) + short_len - WL) begin
            n_fail++;
            $display("FAIL short_pv: got %0d want %0d",
                     pv_n - s_pv, WW * (WH - 1) + short_len - WL);
        end
    endtask

    task automatic test_reset_midframe();
        set_win(WL, WT, WW, WH);
        rst_row = 10;
        rst_seen = 1'b0;
        snap();
        drive_frame();
        n_checks++;
        if (rst_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mrst_outputs: got %b want 0", rst_seen);
        end
        n_checks++;
        if (pv_n !== pv_at_rel) begin
            n_fail++;
            $display("FAIL mrst_silent: got %0d pixels want 0", pv_n - pv_at_rel);
        end
        n_checks++;
        if (fe_n - s_fe !== 0) begin
            n_fail++;
            $display("FAIL mrst_fe: got %0d want 0", fe_n - s_fe);
        end
        rst_row = -1;
        snap();
        drive_frame();
        n_checks++;
        if (pv_n - s_pv !== WW * WH) begin
            n_fail++;
            $display("FAIL mrst_next_pv: got %0d want %0d", pv_n - s_pv, WW * WH);
        end
        n_checks++;
        if (fs_n - s_fs !== 1) begin
            n_fail++;
            $display("FAIL mrst_next_fs: got %0d want 1", fs_n - s_fs);
        end
        n_checks++;
        if (fe_n - s_fe !== 1) begin
            n_fail++;
            $display("FAIL mrst_next_fe: got %0d want 1", fe_n - s_fe);
        end
        n_checks++;
        if (first_data !== 16'h0202) begin
            n_fail++;
            $display("FAIL mrst_next_first: got %h want 0202", first_data);
        end
    endtask

`ifdef ROI_DECIMATE_EN
    task automatic test_decimate();
        set_win(WL, WT, WW, WH);
        cfg_decimate = 1'b1;
        exp_dec = 1;
        snap();
        drive_frame();
        cfg_decimate = 1'b0;
        n_checks++;
        if (pv_n - s_pv !== (WW / 2) * (WH / 2)) begin
            n_fail++;
            $display("FAIL dec_pv: got %0d want %0d",
                     pv_n - s_pv, (WW / 2) * (WH / 2));
        end
        n_checks++;
        if (ls_n - s_ls !== WH / 2) begin
            n_fail++;
            $display("FAIL dec_ls: got %0d want %0d", ls_n - s_ls, WH / 2);
        end
        n_checks++;
        if (oob_n - s_oob !== 0) begin
            n_fail++;
            $display("FAIL dec_window: got %0d stray want 0", oob_n - s_oob);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_full_frame();
        test_zero_width();
        test_cfg_midframe();
        test_short_line();
        test_reset_midframe();
`ifdef ROI_DECIMATE_EN
        test_decimate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_roi_window.md
PIXEL_ROI_WINDOW -- requirements
Module: pixel_roi_window

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel data width.
REQ-002 SHALL have parameter MAX_COLS, default 1024, largest supported line length.
REQ-003 SHALL have parameter MAX_ROWS, default 1024, largest supported frame height.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth (>=2).
REQ-005 SHALL have port clock  input  1  single system clock, all logic on its rising edge.
REQ-006 SHALL have port nreset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports pixclk_in, hsync_in, vsync_in  input  1 each  raw camera timing, asynchronous to clock.
REQ-008 SHALL have port pixdata_in  input  DATA_W  raw camera pixel.
REQ-009 SHALL have ports cfg_left, cfg_width  input  clog2(MAX_COLS)+1 each  window column origin and width.
REQ-010 SHALL have ports cfg_top, cfg_height  input  clog2(MAX_ROWS)+1 each  window row origin and height.
REQ-011 SHALL have ports pix_valid  output  1, and pix_data  output  DATA_W  windowed pixel strobe and value.
REQ-012 SHALL have ports line_start, frame_start, frame_end, line_short_err  output  1 each  one-cycle event pulses.

Function
REQ-013 SHALL pass pixclk_in, hsync_in, vsync_in through SYNC_STAGES flops, and pixdata_in through an equal-length delay.
REQ-014 SHALL sample a pixel on each synchronised pixclk rising edge while synchronised hsync and vsync are both high.
REQ-015 SHALL count columns from 0 per line; column counter clears while hsync is low and saturates at MAX_COLS.
REQ-016 SHALL count rows from 0 per frame, incrementing on each hsync falling edge; row counter clears while vsync is low and saturates at MAX_ROWS.
REQ-017 SHALL latch all cfg_* on the synchronised vsync rising edge; cfg changes mid-frame SHALL NOT affect the current frame.
REQ-018 SHALL assert pix_valid for exactly one cycle per sampled pixel with left<=col<left+width and top<=row<top+height.
REQ-019 SHALL compute window bounds in one extra bit so that left+width cannot wrap.
REQ-020 SHALL assert pix_valid SYNC_STAGES+1 clock cycles after the raw pixclk_in rising edge, provided that edge meets setup at clock.
REQ-021 SHALL pulse line_start together with the first pix_valid of each window row.
REQ-022 SHALL pulse frame_start together with the first pix_valid of a frame.
REQ-023 SHALL pulse frame_end one cycle after the vsync falling edge only if frame_start occurred in that frame.
REQ-024 SHALL pulse line_short_err on an hsync falling edge inside window rows when col < left+width.
REQ-025 SHALL produce no pix_valid in a frame when latched width or height is 0.
REQ-026 SHALL treat a vsync falling edge mid-line as simultaneous end of line and frame, pulsing line_short_err (if applicable) and frame_end in the same cycle.

Reset
REQ-027 SHALL drive, while nreset is low, pix_valid, line_start, frame_start, frame_end and line_short_err to 0, pix_data to 0, clear counters, synchronisers and latched cfg.
REQ-028 SHALL, after mid-frame reset release, ignore the current frame and emit nothing until the next synchronised vsync rising edge.

Configuration
REQ-029 SHALL, with ROI_DECIMATE_EN defined, add input cfg_decimate (1 bit, latched as in REQ-017); when set, emit only even window columns and even window rows relative to the window origin.
REQ-030 SHALL, without ROI_DECIMATE_EN, have no cfg_decimate port and emit every window pixel.

Structure
REQ-031 SHALL place the shared window-config typedef (left, top, width, height), the counter-width functions and the default geometry constants (324x244 sensor, 320x240 window) in package jfpjc_pkg.
REQ-032 SHALL use one sub-module, sync_edge_detect, which performs synchronisation plus rising and falling edge detection for pixclk, hsync and vsync.

Verification
REQ-033 SHALL test a 324x244 frame with left=2, top=2, width=320, height=240: 76800 pix_valid, 240 line_start, 1 frame_start, 1 frame_end, pixel (2,2) first.
REQ-034 SHALL test width=0, height=240: 0 pix_valid, 0 frame_start, 0 frame_end.
REQ-035 SHALL test cfg_left changed from 2 to 10 mid-frame: current frame uses 2, next frame's first pixel is column 10.
REQ-036 SHALL test line 5 truncated to 100 pixels with left=2, width=320: exactly one line_short_err, other lines emit 320 pixels.
REQ-037 SHALL test nreset asserted at row 100 then released: outputs 0 during reset, no pix_valid until the next vsync rising edge, then a full 76800-pixel frame.
REQ-038 SHALL test, with ROI_DECIMATE_EN and cfg_decimate=1 on the REQ-033 frame: 19200 pix_valid, 120 line_start.
